fetch_inst_buffer: RTL and testbench
====================================

// Module: fetch_inst_buffer
// PURPOSE
//  Decoupling queue between fetch and the backend's instruction-entry port.
//  Accepts up to IN_WIDTH fetched entries per cycle, with arbitrary lane validity, and compacts them into a circular buffer.
//  Presents up to OUT_WIDTH oldest entries to the backend, which consumes them whenever its stall is low.
//  Flushed entirely on backend squash.
// PARAMETERS
//  IN_WIDTH   4    enqueue lanes from fetch
//  OUT_WIDTH  4    dequeue lanes to backend (== FETCH_WIDTH)
//  DEPTH      16   entries; power of 2, >= IN_WIDTH + OUT_WIDTH
//  ENTRY_W    64   bit width of one packed fetchEntry_t
// PORTS
//  clk         in   1                   clock
//  rst         in   1                   synchronous reset, active-low
//  i_squash_vld in  1                   flush all entries
//  i_enq_vld   in   IN_WIDTH            per-lane valid from fetch
//  i_enq_data  in   IN_WIDTH x ENTRY_W  per-lane entry
//  o_enq_rdy   out  1                   buffer has >= IN_WIDTH free slots
//  o_deq_vld   out  OUT_WIDTH           per-lane valid to backend, thermometer from lane 0
//  o_deq_data  out  OUT_WIDTH x ENTRY_W oldest entries, lane 0 oldest
//  i_stall     in   1                   backend stall (backend o_stall)
//  o_count     out  log2(DEPTH)+1       occupied entries
// BEHAVIOUR
//  - State: mem[DEPTH], head/tail pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
//    Pointers wrap modulo DEPTH naturally.
//  - Reset (rst==0 at posedge): head=tail=count=0.
//    Outputs after reset: o_deq_vld=0, o_enq_rdy=1, o_count=0. mem contents are not reset.
//  - o_enq_rdy = (DEPTH - count) >= IN_WIDTH. This is combinational from registered count, with no dependence on this cycle's deq.
//  - Enqueue fires when o_enq_rdy && |i_enq_vld && !i_squash_vld.
//    Compaction: valid lane k is written to mem[tail + popcount(i_enq_vld[k-1:0])].
//    tail advances by popcount(i_enq_vld).
//    If o_enq_rdy==0, all lanes are ignored; upstream must hold its data.
//  - Dequeue: ndeq = min(count, OUT_WIDTH); o_deq_vld[k] = (k < ndeq); o_deq_data[k] = mem[head+k].
//    Invalid lanes' data is don't-care.
//    If !i_stall && !i_squash_vld, head advances by ndeq. This is an all-or-nothing group consume.
//  - count_next = count + nenq - ndeq_fired. Simultaneous enq and deq are both applied in the same cycle.
//  - Latency: an entry enqueued at cycle N is visible on o_deq_* at N+1. No bypass path.
//  - Squash: head=tail=count=0 next cycle. Squash has priority over same-cycle enq and deq; nothing is written or consumed.
//  - Reset has priority over squash. Reset mid-operation discards all contents.
//  - Full: count==DEPTH gives o_enq_rdy=0 and o_deq_vld all ones.
//    Empty: o_deq_vld=0, and i_stall has no effect.
//  - count never exceeds DEPTH. Assert: nenq <= DEPTH - count whenever enqueue fires.
// TESTING
//  T1 reset: hold rst=0 for 2 cycles -> o_deq_vld=0, o_enq_rdy=1, o_count=0.
//  T2 compaction: i_stall=1, i_enq_vld=4'b0101 (lane0=A, lane2=B)
//     -> next cycle o_deq_vld=4'b0011, data[0]=A, data[1]=B, o_count=2.
//  T3 full: i_stall=1, enqueue 4 full groups
//     -> counts 4, 8, 12 with rdy=1 each time; after the 4th group count=16 and rdy=0.
//     A 5th enqueue attempt is ignored and count stays 16.
//  T4 simultaneous: count=6, i_stall=0, enqueue 4 entries -> count=6 (4 out, 4 in).
//     Next cycle lane 0 shows the 5th-oldest entry.
//  T5 squash: count=9, i_squash_vld=1 with i_enq_vld=4'b1111 and i_stall=0
//     -> next cycle count=0, o_deq_vld=0, o_enq_rdy=1.
//  T6 wrap/order: stream 40 entries with random lane masks and random i_stall
//     -> output order equals input order across pointer wrap, and no loss or duplication.

Source files
------------

// File: rtl/fetch_inst_buffer_if.sv
// rtl/fetch_inst_buffer_if.sv - fetch/backend handshake bundle for the instruction buffer
interface fetch_inst_buffer_if #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int ENTRY_W   = 64,
    parameter int CNT_W     = 5
);
    logic                                i_squash_vld;
    logic [IN_WIDTH-1:0]                 i_enq_vld;
    logic [IN_WIDTH-1:0][ENTRY_W-1:0]    i_enq_data;
    logic                                o_enq_rdy;
    logic [OUT_WIDTH-1:0]                o_deq_vld;
    logic [OUT_WIDTH-1:0][ENTRY_W-1:0]   o_deq_data;
    logic                                i_stall;
    logic [CNT_W-1:0]                    o_count;

    modport master (
        output i_squash_vld, i_enq_vld, i_enq_data, i_stall,
        input  o_enq_rdy, o_deq_vld, o_deq_data, o_count
    );

    modport slave (
        input  i_squash_vld, i_enq_vld, i_enq_data, i_stall,
        output o_enq_rdy, o_deq_vld, o_deq_data, o_count
    );
endinterface

// File: rtl/fetch_inst_buffer.sv
// rtl/fetch_inst_buffer.sv - compacting circular instruction buffer between fetch and backend
module fetch_inst_buffer #(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 16,
    parameter int ENTRY_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    fetch_inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PW-1:0]      head;
    logic [PW-1:0]      tail;
    logic [CW-1:0]      count;

    logic [CW-1:0]                free;
    logic                         enq_rdy;
    logic                         enq_fire;
    logic                         deq_fire;
    logic [CW-1:0]                nenq;
    logic [CW-1:0]                ndeq;
    logic [IN_WIDTH-1:0][CW-1:0]  lane_off;

    assign free     = CW'(DEPTH) - count;
    assign enq_rdy  = free >= CW'(IN_WIDTH);
    assign enq_fire = enq_rdy && (|bus.i_enq_vld) && !bus.i_squash_vld;
    assign deq_fire = !bus.i_stall && !bus.i_squash_vld;
    assign ndeq     = (count < CW'(OUT_WIDTH)) ? count : CW'(OUT_WIDTH);

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        nenq     = '0;
        lane_off = '0;
        for (int k = 0; k < IN_WIDTH; k++) begin
            lane_off[k] = nenq;
            nenq        = nenq + CW'(bus.i_enq_vld[k]);
        end
    end

    always_comb begin
        bus.o_deq_vld  = '0;
        bus.o_deq_data = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            bus.o_deq_vld[k]  = CW'(k) < ndeq;
            bus.o_deq_data[k] = mem[head + PW'(k)];
        end
    end

    assign bus.o_enq_rdy = enq_rdy;
    assign bus.o_count   = count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (bus.i_squash_vld) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PW'(nenq);
            end
            if (deq_fire) begin
                head <= head + PW'(ndeq);
            end
            count <= count + (enq_fire ? nenq : CW'(0)) - (deq_fire ? ndeq : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (rst && enq_fire) begin
            for (int k = 0; k < IN_WIDTH; k++) begin
                if (bus.i_enq_vld[k]) begin
                    mem[tail + PW'(lane_off[k])] <= bus.i_enq_data[k];
                end
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        enq_fire |-> (nenq <= free));
endmodule

// File: tb/tb_fetch_inst_buffer.sv
// tb/tb_fetch_inst_buffer.sv - scoreboard bench for fetch_inst_buffer
module tb_fetch_inst_buffer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   pushed_total;
    int   popped_total;
    logic [63:0] exp_q [$];

    fetch_inst_buffer_if #(.IN_WIDTH(4), .OUT_WIDTH(4), .ENTRY_W(64), .CNT_W(5)) bus ();

    fetch_inst_buffer #(.IN_WIDTH(4), .OUT_WIDTH(4), .DEPTH(16), .ENTRY_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: the queue holds exactly the buffer contents, oldest first.
    always @(negedge clk) begin
        int n;
        if (rst) begin
            n = (exp_q.size() < 4) ? exp_q.size() : 4;
            check("mon_deq_vld", 64'(bus.o_deq_vld), 64'((5'b1 << n) - 5'b1));
            check("mon_count", 64'(bus.o_count), 64'(exp_q.size()));
            check("mon_enq_rdy", 64'(bus.o_enq_rdy), 64'((16 - exp_q.size()) >= 4));
            for (int k = 0; k < n; k++) begin
                check("mon_deq_data", bus.o_deq_data[k], exp_q[k]);
            end
            if (!bus.i_stall && !bus.i_squash_vld) begin
                for (int k = 0; k < n; k++) begin
                    void'(exp_q.pop_front());
                    popped_total++;
                end
            end
        end
    end

    // Called at posedge+1; returns at the next posedge+1.
    task automatic tick(input logic [3:0] vld, input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [63:0] d3,
                        input logic stall, input logic sq, output logic acc);
        logic [63:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        bus.i_enq_vld    = vld;
        for (int k = 0; k < 4; k++) bus.i_enq_data[k] = d[k];
        bus.i_stall      = stall;
        bus.i_squash_vld = sq;
        acc = ((16 - exp_q.size()) >= 4) && (|vld) && !sq;
        @(posedge clk);
        if (sq) begin
            exp_q.delete();
        end else if (acc) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k]) begin
                    exp_q.push_back(d[k]);
                    pushed_total++;
                end
            end
        end
        #1;
        bus.i_enq_vld    = '0;
        bus.i_squash_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst              = 1'b0;
        bus.i_enq_vld    = '0;
        bus.i_squash_vld = 1'b0;
        bus.i_stall      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b1;
    endtask

    initial begin
        logic        acc;
        logic [3:0]  mask;
        logic        stall;
        logic [63:0] d [4];
        int          sent;
        int          j;
        n_checks = 0; n_fail = 0; pushed_total = 0; popped_total = 0;
        bus.i_enq_data = '0;

        // T1 reset
        do_reset();
        check("t1_deq_vld", 64'(bus.o_deq_vld), 64'h0);
        check("t1_enq_rdy", 64'(bus.o_enq_rdy), 64'h1);
        check("t1_count", 64'(bus.o_count), 64'h0);

        // T2 compaction
        tick(4'b0101, 64'hA, 64'hDEAD, 64'hB, 64'hBEEF, 1'b1, 1'b0, acc);
        check("t2_deq_vld", 64'(bus.o_deq_vld), 64'h3);
        check("t2_data0", bus.o_deq_data[0], 64'hA);
        check("t2_data1", bus.o_deq_data[1], 64'hB);
        check("t2_count", 64'(bus.o_count), 64'd2);

        // T3 full
        do_reset();
        for (int g = 0; g < 4; g++) begin
            tick(4'b1111, 64'(g*4), 64'(g*4+1), 64'(g*4+2), 64'(g*4+3), 1'b1, 1'b0, acc);
            check("t3_count", 64'(bus.o_count), 64'((g + 1) * 4));
            check("t3_enq_rdy", 64'(bus.o_enq_rdy), (g < 3) ? 64'h1 : 64'h0);
        end
        check("t3_deq_vld_full", 64'(bus.o_deq_vld), 64'hF);
        tick(4'b1111, 64'h90, 64'h91, 64'h92, 64'h93, 1'b1, 1'b0, acc);
        check("t3_count_hold", 64'(bus.o_count), 64'd16);
        check("t3_data0_hold", bus.o_deq_data[0], 64'h0);

        // T4 simultaneous enqueue and dequeue
        do_reset();
        tick(4'b1111, 64'h10, 64'h11, 64'h12, 64'h13, 1'b1, 1'b0, acc);
        tick(4'b0011, 64'h20, 64'h21, 64'h0, 64'h0, 1'b1, 1'b0, acc);
        check("t4_count_pre", 64'(bus.o_count), 64'd6);
        tick(4'b1111, 64'h30, 64'h31, 64'h32, 64'h33, 1'b0, 1'b0, acc);
        check("t4_count", 64'(bus.o_count), 64'd6);
        check("t4_data0", bus.o_deq_data[0], 64'h20);
        check("t4_data2", bus.o_deq_data[2], 64'h30);

        // T5 squash beats enqueue and dequeue
        do_reset();
        tick(4'b1111, 64'h40, 64'h41, 64'h42, 64'h43, 1'b1, 1'b0, acc);
        tick(4'b1111, 64'h44, 64'h45, 64'h46, 64'h47, 1'b1, 1'b0, acc);
        tick(4'b0001, 64'h48, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, acc);
        check("t5_count_pre", 64'(bus.o_count), 64'd9);
        tick(4'b1111, 64'h50, 64'h51, 64'h52, 64'h53, 1'b0, 1'b1, acc);
        check("t5_count", 64'(bus.o_count), 64'd0);
        check("t5_deq_vld", 64'(bus.o_deq_vld), 64'h0);
        check("t5_enq_rdy", 64'(bus.o_enq_rdy), 64'h1);

        // T6 streaming across pointer wrap
        do_reset();
        pushed_total = 0;
        popped_total = 0;
        sent = 0;
        for (int it = 0; it < 400 && sent < 40; it++) begin
            mask  = 4'($urandom_range(1, 15));
            stall = 1'($urandom_range(0, 1));
            j = 0;
            for (int k = 0; k < 4; k++) begin
                d[k] = 64'h0;
                if (mask[k]) begin
                    d[k] = 64'(1000 + sent + j);
                    j++;
                end
            end
            tick(mask, d[0], d[1], d[2], d[3], stall, 1'b0, acc);
            if (acc) sent += $countones(mask);
        end
        check("t6_sent", 64'(sent >= 40), 64'h1);
        for (int i = 0; i < 10; i++) begin
            tick(4'b0000, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, acc);
        end
        check("t6_drained_count", 64'(bus.o_count), 64'h0);
        check("t6_queue_empty", 64'(exp_q.size()), 64'h0);
        check("t6_no_loss", 64'(popped_total), 64'(sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
